hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised register scoreboard replacing the fixed two-stage hazard/forwarding logic of the pipelined processor. It sits beside the decode stage and tracks, per architectural register, the cycles until a pending result reaches the execute result, the writeback stage and the register file. From that state it generates the decode stall, the `forward_A`/`forward_B` operand selects (same 2-bit encoding as the existing datapath) and a saturating stall counter. It supports variable-latency producers (LOAD, MUL/DIV) and the MUL/DIV secondary write to a fixed register.

## Interface
- `NUM_REGS`, 8, number of architectural registers.
- `ADDR_W`, 3, register address width; `NUM_REGS <= 2**ADDR_W`.
- `LAT_W`, 3, countdown width; legal producer latency is 1..`2**LAT_W-2`.
- `SEC_REG`, 1, secondary destination written by MUL/DIV high result.
- `FWD_EN`, 1, 1 = forwarding enabled; 0 = stall until the register file holds the value.
- `STALL_CNT_W`, 16, stall counter width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `issue_valid` in 1: an instruction is present in decode.
- `rs1_addr` / `rs2_addr` in `ADDR_W`: source registers.
- `rs1_used` / `rs2_used` in 1: the corresponding source is read.
- `rd_addr` in `ADDR_W`; `rd_write` in 1: primary destination and its enable.
- `rd2_write` in 1: the instruction also writes `SEC_REG`.
- `lat` in `LAT_W`: cycles from issue to result at the execute-stage result bus.
- `flush` in 1: squash the decode instruction; it does not issue.
- `stall` out 1: hold F and D.
- `issue_fire` out 1: `issue_valid & !stall & !flush`.
- `fwd_a` / `fwd_b` out 2: 00 register file, 01 execute result, 10 writeback data.
- `busy_mask` out `NUM_REGS`: bit r set when `cnt[r] != 0`.
- `idle` out 1: `busy_mask == 0`; used for HALT drain.
- `stall_cnt` out `STALL_CNT_W`: stall cycles seen.

## Operation
- **State.** One `LAT_W`-bit counter `cnt[r]` per register. 0 means the register file is current.
- **Latency normalisation.** `lat = 0` is treated as 1. `lat = 2**LAT_W-1` is clamped to `2**LAT_W-2`. Call the result `L`.
- **Issue.** On `issue_fire`:
  - if `rd_write`, `cnt[rd_addr] <= L+1`;
  - if `rd2_write`, `cnt[SEC_REG] <= L+1`;
  - if both target the same register, the value is identical.
- **Decrement.** Every other nonzero counter decrements by 1 each cycle. An issue write wins over the decrement for the same register.
- **Source state** for each source `s` with `*_used`, where `c = cnt[s]`:
  - `c == 0`: fwd 00, no hazard;
  - `c == 1`: value is at writeback, fwd 10 (if `FWD_EN=0`, hazard);
  - `c == 2`: value is on the execute result bus, fwd 01 (if `FWD_EN=0`, hazard);
  - `c >= 3`: hazard.
- **Unused sources** give fwd 00 and no hazard.
- **WAW rule.** If `rd_write` and `cnt[rd_addr] > L+1`, it is a hazard. The same check applies to `SEC_REG` when `rd2_write`. This prevents out-of-order completion.
- **Stall.** `stall = issue_valid & (any hazard)`. `flush` does not mask `stall`, but it blocks issue.
- **Stall counter.** Increments when `stall` is 1 and saturates at all-ones.
- **Addresses.** Any address `>= NUM_REGS` is treated as never busy and is never written.

## Timing
- `stall`, `issue_fire`, `fwd_a`, `fwd_b`, `busy_mask` and `idle` are combinational from state and inputs. No latency is added to the decode path.
- Counters and `stall_cnt` update on the rising edge of `clk`.
- **Producer timeline.** For a producer issuing in cycle t with latency L:
  - `cnt = L+1` at cycle t+1, then decrements each cycle;
  - at t+L: `cnt = 2`, consumer forwards from execute;
  - at t+L+1: `cnt = 1`, consumer forwards from writeback;
  - at t+L+2: `cnt = 0`, consumer reads the register file.
- **Reset.** While `rst` is high, all `cnt` load 0 on the edge and `stall_cnt` loads 0. Outputs are forced during reset: `stall=0`, `issue_fire=0`, `fwd=00`, `busy_mask=0`, `idle=1`.
- **Reset mid-operation** discards all pending entries with no residual stall.
- **Simultaneous events.**
  - Issue to register r while `cnt[r]` would decrement: the issue value is stored.
  - A consumer reading r in the same cycle that a new producer of r issues sees the old count. The new count applies from the next cycle.

## Test plan
- **INC chain, FWD_EN=1.** Issue R1<-R0 (`rd=1`, `lat=1`) at t; at t+1 issue with `rs1=1` -> `stall=0`, `fwd_a=01`.
- **Load-use.** Issue `rd=3`, `lat=2`; next cycle `rs1=3` -> `stall=1` for 1 cycle, then `fwd_a=01`. `stall_cnt` increments from 0 to 1.
- **MUL with secondary write.** Issue `rd=2`, `rd2_write=1`, `lat=3`; consumer with `rs2=1` the next cycle -> stall 2 cycles, then `fwd_b=01`. A consumer one cycle later gets `fwd_b=10`.
- **FWD_EN=0.** A `lat=1` producer followed by a dependent instruction -> stall 2 cycles, then `fwd=00`, and `idle=1` once drained.
- **WAW.** Issue `rd=4`, `lat=5`; next cycle issue `rd=4`, `lat=1` -> stall 4 cycles (cnt 6,5,4,3), issue at cnt 2, then `cnt[4]=2`.
- **Reset and saturation.**
  - With `busy_mask=0x1C`, assert `rst` for 1 cycle -> `busy_mask=0`, `stall_cnt=0`, next instruction issues with no stall.
  - Force `stall_cnt` to 0xFFFF and stall once more -> it stays at 0xFFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard beside decode: tracks cycles until each pending result reaches
// the register file, and derives decode stall, operand forwarding selects and a stall counter.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned LAT_W       = 3,
  parameter int unsigned SEC_REG     = 1,
  parameter bit          FWD_EN      = 1'b1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   issue_valid_i,
  input  logic [ADDR_W-1:0]      rs1_addr_i,
  input  logic [ADDR_W-1:0]      rs2_addr_i,
  input  logic                   rs1_used_i,
  input  logic                   rs2_used_i,
  input  logic [ADDR_W-1:0]      rd_addr_i,
  input  logic                   rd_write_i,
  input  logic                   rd2_write_i,
  input  logic [LAT_W-1:0]       lat_i,
  input  logic                   flush_i,
  output logic                   stall_o,
  output logic                   issue_fire_o,
  output logic [1:0]             fwd_a_o,
  output logic [1:0]             fwd_b_o,
  output logic [NUM_REGS-1:0]    busy_mask_o,
  output logic                   idle_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'((2 ** LAT_W) - 2);

  logic [LAT_W-1:0]       cnt_q [NUM_REGS];
  logic [LAT_W-1:0]       cnt_d [NUM_REGS];
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d;

  logic [LAT_W-1:0] lat_norm;
  logic [LAT_W-1:0] cnt_new;
  logic [LAT_W-1:0] c_rs1, c_rs2, c_rd, c_sec;
  logic [2:0]       eval_a, eval_b;
  logic             waw_haz, stall_raw, fire_raw;

  // {hazard, fwd} for one source given the remaining count of its register
  function automatic logic [2:0] src_eval(input logic used, input logic [LAT_W-1:0] c);
    logic       haz;
    logic [1:0] fwd;
    haz = 1'b0;
    fwd = 2'b00;
    if (used) begin
      if (c >= LAT_W'(3)) begin
        haz = 1'b1;
      end else if (c != '0) begin
        if (FWD_EN) fwd = (c == LAT_W'(1)) ? 2'b10 : 2'b01;
        else        haz = 1'b1;
      end
    end
    return {haz, fwd};
  endfunction

  always_comb begin
    lat_norm = lat_i;
    if (lat_i == '0)      lat_norm = LAT_W'(1);
    else if (lat_i == '1) lat_norm = LAT_MAX;
    cnt_new = lat_norm + LAT_W'(1);

    // Out-of-range addresses match no entry and read as idle
    c_rs1 = '0;
    c_rs2 = '0;
    c_rd  = '0;
    c_sec = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (rs1_addr_i == ADDR_W'(r)) c_rs1 = cnt_q[r];
      if (rs2_addr_i == ADDR_W'(r)) c_rs2 = cnt_q[r];
      if (rd_addr_i == ADDR_W'(r))  c_rd  = cnt_q[r];
      if (r == SEC_REG)             c_sec = cnt_q[r];
    end

    eval_a    = src_eval(rs1_used_i, c_rs1);
    eval_b    = src_eval(rs2_used_i, c_rs2);
    waw_haz   = (rd_write_i && (c_rd > cnt_new)) || (rd2_write_i && (c_sec > cnt_new));
    stall_raw = issue_valid_i && (eval_a[2] || eval_b[2] || waw_haz);
    fire_raw  = issue_valid_i && !stall_raw && !flush_i;

    stall_o      = !rst_i && stall_raw;
    issue_fire_o = !rst_i && fire_raw;
    fwd_a_o      = rst_i ? 2'b00 : eval_a[1:0];
    fwd_b_o      = rst_i ? 2'b00 : eval_b[1:0];

    // Issue write takes priority over the per-cycle decrement
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
      if (fire_raw && rd_write_i && (rd_addr_i == ADDR_W'(r))) cnt_d[r] = cnt_new;
      if (fire_raw && rd2_write_i && (r == SEC_REG))           cnt_d[r] = cnt_new;
      busy_mask_o[r] = !rst_i && (cnt_q[r] != '0);
    end
    idle_o = (busy_mask_o == '0);

    stall_cnt_d = stall_cnt_q;
    if (stall_raw && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    stall_cnt_o = stall_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
